// File: rtl/alu_op_sequencer_pkg.sv
// Shared constants for the ALU operation sequencer: ALUOp encodings, ALU
// operation codes, funct7 classes, FSM state encoding and the base
// funct3 -> operation table shared by R-type and I-arith decode.
package alu_op_pkg;

   localparam logic [2:0] ALUOP_R      = 3'b000;
   localparam logic [2:0] ALUOP_I      = 3'b001;
   localparam logic [2:0] ALUOP_AUIPC  = 3'b010;
   localparam logic [2:0] ALUOP_LOAD   = 3'b011;
   localparam logic [2:0] ALUOP_STORE  = 3'b100;
   localparam logic [2:0] ALUOP_BRANCH = 3'b101;
   localparam logic [2:0] ALUOP_LUI    = 3'b110;
   localparam logic [2:0] ALUOP_JAL    = 3'b111;

   localparam int OP_CODE_W = 5;

   localparam logic [OP_CODE_W-1:0] OP_ADD    = 5'd0;
   localparam logic [OP_CODE_W-1:0] OP_SUB    = 5'd1;
   localparam logic [OP_CODE_W-1:0] OP_SLL    = 5'd2;
   localparam logic [OP_CODE_W-1:0] OP_SLT    = 5'd3;
   localparam logic [OP_CODE_W-1:0] OP_SLTU   = 5'd4;
   localparam logic [OP_CODE_W-1:0] OP_XOR    = 5'd5;
   localparam logic [OP_CODE_W-1:0] OP_SRL    = 5'd6;
   localparam logic [OP_CODE_W-1:0] OP_SRA    = 5'd7;
   localparam logic [OP_CODE_W-1:0] OP_OR     = 5'd8;
   localparam logic [OP_CODE_W-1:0] OP_AND    = 5'd9;
   localparam logic [OP_CODE_W-1:0] OP_PASSB  = 5'd10;
   localparam logic [OP_CODE_W-1:0] OP_MUL    = 5'd11;
   localparam logic [OP_CODE_W-1:0] OP_MULH   = 5'd12;
   localparam logic [OP_CODE_W-1:0] OP_MULHSU = 5'd13;
   localparam logic [OP_CODE_W-1:0] OP_MULHU  = 5'd14;
   localparam logic [OP_CODE_W-1:0] OP_DIV    = 5'd15;
   localparam logic [OP_CODE_W-1:0] OP_DIVU   = 5'd16;
   localparam logic [OP_CODE_W-1:0] OP_REM    = 5'd17;
   localparam logic [OP_CODE_W-1:0] OP_REMU   = 5'd18;

   localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
   localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   // funct3 -> operation for the plain (funct7 == 0) integer ops
   function automatic logic [OP_CODE_W-1:0] base_op(input logic [2:0] funct3);
      logic [OP_CODE_W-1:0] op;
      case (funct3)
         3'b000:  op = OP_ADD;
         3'b001:  op = OP_SLL;
         3'b010:  op = OP_SLT;
         3'b011:  op = OP_SLTU;
         3'b100:  op = OP_XOR;
         3'b101:  op = OP_SRL;
         3'b110:  op = OP_OR;
         default: op = OP_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// ID/EX handshake bundle between the ID stage (master) and the ALU
// operation sequencer (slave).
interface alu_op_sequencer_if #(
   parameter int OP_W = 5
);
   logic            valid_i;
   logic [6:0]      funct7_i;
   logic [2:0]      funct3_i;
   logic [2:0]      alu_op_i;
   logic            flush_i;
   logic            ready_o;
   logic            op_valid_o;
   logic [OP_W-1:0] alu_operation_o;
   logic            illegal_o;
   logic            mdu_start_o;
   logic            mdu_done_o;
   logic            stall_o;

   modport master (
      output valid_i, funct7_i, funct3_i, alu_op_i, flush_i,
      input  ready_o, op_valid_o, alu_operation_o, illegal_o,
             mdu_start_o, mdu_done_o, stall_o
   );

   modport slave (
      input  valid_i, funct7_i, funct3_i, alu_op_i, flush_i,
      output ready_o, op_valid_o, alu_operation_o, illegal_o,
             mdu_start_o, mdu_done_o, stall_o
   );
endinterface

// File: rtl/alu_op_sequencer_decoder.sv
// Combinational decode of {funct7, funct3, ALUOp} into an ALU operation
// code plus illegal / multiply / divide classification.
// Macro ALU_OP_SEQ_RV32M_EN enables the RV32M (funct7 0000001) ops;
// without it those encodings decode as illegal.
module alu_op_decoder
   import alu_op_pkg::*;
(
   input  logic [6:0]           funct7,
   input  logic [2:0]           funct3,
   input  logic [2:0]           alu_op,
   output logic [OP_CODE_W-1:0] op,
   output logic                 illegal,
   output logic                 is_mul,
   output logic                 is_div
);

   // Illegal encodings fall through with op left at ADD
   always_comb begin
      op      = OP_ADD;
      illegal = 1'b0;
      is_mul  = 1'b0;
      is_div  = 1'b0;
      case (alu_op)
         ALUOP_R: begin
            if (funct7 == FUNCT7_BASE) begin
               op = base_op(funct3);
            end else if (funct7 == FUNCT7_ALT) begin
               if (funct3 == 3'b000) begin
                  op = OP_SUB;
               end else if (funct3 == 3'b101) begin
                  op = OP_SRA;
               end else begin
                  illegal = 1'b1;
               end
            end
`ifdef ALU_OP_SEQ_RV32M_EN
            else if (funct7 == FUNCT7_MULDIV) begin
               op     = OP_MUL + {2'b00, funct3};
               is_mul = !funct3[2];
               is_div = funct3[2];
            end
`endif
            else begin
               illegal = 1'b1;
            end
         end
         ALUOP_I: begin
            if (funct3 == 3'b001) begin
               if (funct7 == FUNCT7_BASE) begin
                  op = OP_SLL;
               end else begin
                  illegal = 1'b1;
               end
            end else if (funct3 == 3'b101) begin
               if (funct7 == FUNCT7_BASE) begin
                  op = OP_SRL;
               end else if (funct7 == FUNCT7_ALT) begin
                  op = OP_SRA;
               end else begin
                  illegal = 1'b1;
               end
            end else begin
               op = base_op(funct3);
            end
         end
         ALUOP_BRANCH: begin
            case (funct3[2:1])
               2'b00:   op = OP_SUB;
               2'b10:   op = OP_SLT;
               2'b11:   op = OP_SLTU;
               default: illegal = 1'b1;
            endcase
         end
         ALUOP_LUI: op = OP_PASSB;
         default:   op = OP_ADD;
      endcase
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Registered ALU operation decode on the ID/EX boundary. Single-cycle ops
// are presented one cycle after accept; MUL/DIV ops additionally hold the
// pipeline for MUL_LAT / DIV_LAT cycles and pulse start/done to the MDU.
// Macro ALU_OP_SEQ_RV32M_EN enables RV32M decode and the BUSY sequencing;
// without it the sequencer is a plain registered decoder that never stalls.
module alu_op_sequencer
   import alu_op_pkg::*;
#(
   parameter int OP_W    = 5,
   parameter int MUL_LAT = 2,
   parameter int DIV_LAT = 33
) (
   input logic              clk,
   input logic              reset,
   alu_op_sequencer_if.slave bus
);

   logic [OP_CODE_W-1:0] dec_op;
   logic                 dec_illegal;
   logic                 dec_is_mul;
   logic                 dec_is_div;
   logic                 accept;
   logic                 op_valid_q;
   logic [OP_W-1:0]      op_q;
   logic                 illegal_q;

   alu_op_decoder u_decoder (
      .funct7  (bus.funct7_i),
      .funct3  (bus.funct3_i),
      .alu_op  (bus.alu_op_i),
      .op      (dec_op),
      .illegal (dec_illegal),
      .is_mul  (dec_is_mul),
      .is_div  (dec_is_div)
   );

   assign bus.op_valid_o      = op_valid_q;
   assign bus.alu_operation_o = op_q;
   assign bus.illegal_o       = illegal_q;

`ifdef ALU_OP_SEQ_RV32M_EN
   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             start_q;

   assign accept = bus.valid_i && (state == ST_IDLE) && !bus.flush_i;

   // FSM: IDLE accepts and registers the decode; BUSY counts the MDU latency down
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         op_valid_q <= 1'b0;
         op_q       <= '0;
         illegal_q  <= 1'b0;
         start_q    <= 1'b0;
      end else begin
         start_q <= 1'b0;
         if (state == ST_IDLE) begin
            op_valid_q <= accept;
            if (accept) begin
               op_q      <= OP_W'(dec_op);
               illegal_q <= dec_illegal;
               if (dec_is_mul) begin
                  state   <= ST_BUSY;
                  cnt     <= CNT_W'(MUL_LAT - 1);
                  start_q <= 1'b1;
               end else if (dec_is_div) begin
                  state   <= ST_BUSY;
                  cnt     <= CNT_W'(DIV_LAT - 1);
                  start_q <= 1'b1;
               end
            end
         end else begin
            if (bus.flush_i) begin
               state      <= ST_IDLE;
               cnt        <= '0;
               op_valid_q <= 1'b0;
            end else if (cnt == '0) begin
               state      <= ST_IDLE;
               op_valid_q <= 1'b0;
            end else begin
               cnt <= cnt - 1'b1;
            end
         end
      end
   end

   assign bus.ready_o     = (state == ST_IDLE);
   assign bus.stall_o     = (state == ST_BUSY);
   assign bus.mdu_start_o = start_q;
   assign bus.mdu_done_o  = (state == ST_BUSY) && (cnt == '0) && !bus.flush_i && reset;
`else
   localparam int unused_lat = MUL_LAT + DIV_LAT;
   logic unused_mdu;

   assign unused_mdu = dec_is_mul | dec_is_div;
   assign accept     = bus.valid_i && !bus.flush_i;

   // Plain registered decode: every accepted op is single-cycle
   always_ff @(posedge clk) begin
      if (!reset) begin
         op_valid_q <= 1'b0;
         op_q       <= '0;
         illegal_q  <= 1'b0;
      end else begin
         op_valid_q <= accept;
         if (accept) begin
            op_q      <= OP_W'(dec_op);
            illegal_q <= dec_illegal;
         end
      end
   end

   assign bus.ready_o     = 1'b1;
   assign bus.stall_o     = 1'b0;
   assign bus.mdu_start_o = 1'b0;
   assign bus.mdu_done_o  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard testbench for alu_op_sequencer: directed vectors push their
// hand-computed decode into a queue; a negedge monitor pops and compares
// whenever a new operation is presented. Sequencing, flush and reset
// behaviour are checked directly by the stimulus process.
module tb_alu_op_sequencer;

   localparam logic [2:0] A_R      = 3'b000;
   localparam logic [2:0] A_I      = 3'b001;
   localparam logic [2:0] A_BRANCH = 3'b101;
   localparam logic [2:0] A_LUI    = 3'b110;
   localparam logic [2:0] A_JAL    = 3'b111;
   localparam logic [6:0] F7_BASE  = 7'b0000000;
   localparam logic [6:0] F7_ALT   = 7'b0100000;
   localparam logic [6:0] F7_MD    = 7'b0000001;

   typedef struct packed {
      logic [4:0] op;
      logic       ill;
      logic       mdu;
   } exp_t;

   logic clk;
   logic reset;
   int   tests;
   int   failures;
   exp_t sb[$];
   exp_t monE;
   logic prevValid;
   logic prevReady;

   alu_op_sequencer_if #(.OP_W(5)) bus ();

   alu_op_sequencer #(
      .OP_W    (5),
      .MUL_LAT (2),
      .DIV_LAT (33)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running clock, period 10
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      tests++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Wait for ready, record the expected decode, hold valid across one edge
   task automatic applyStimulus(input logic [6:0] f7, input logic [2:0] f3, input logic [2:0] aop,
                                input logic [4:0] expOp, input logic expIll, input logic expMdu);
      int   waitCnt = 0;
      exp_t e;
      while (!bus.ready_o && waitCnt < 100) begin
         @(posedge clk);
         #1;
         waitCnt++;
      end
      if (!bus.ready_o) begin
         tests++;
         failures++;
         $display("[TB] FAIL ready_timeout: ready_o=0 after %0d cycles, expected 1", waitCnt);
         return;
      end
      e.op  = expOp;
      e.ill = expIll;
      e.mdu = expMdu;
      sb.push_back(e);
      bus.funct7_i = f7;
      bus.funct3_i = f3;
      bus.alu_op_i = aop;
      bus.valid_i  = 1'b1;
      @(posedge clk);
      #1;
      bus.valid_i = 1'b0;
   endtask

   // Observe a running MDU op from its first BUSY cycle to the cycle after done
   task automatic measureBusy(input string name, input int lat);
      int   stallCnt = 0;
      int   doneAt = -1;
      int   doneCnt = 0;
      int   startCnt = 0;
      int   validCnt = 0;
      logic readyAfter = 1'b0;
      for (int i = 0; i < lat + 20; i++) begin
         @(negedge clk);
         if (!bus.stall_o) begin
            readyAfter = bus.ready_o;
            break;
         end
         stallCnt++;
         if (bus.op_valid_o) validCnt++;
         if (bus.mdu_start_o) startCnt++;
         if (bus.mdu_done_o) begin
            doneCnt++;
            doneAt = stallCnt;
         end
      end
      checkOutput({name, "_stall_cycles"}, stallCnt, lat);
      checkOutput({name, "_done_cycle"}, doneAt, lat);
      checkOutput({name, "_done_pulses"}, doneCnt, 1);
      checkOutput({name, "_start_pulses"}, startCnt, 1);
      checkOutput({name, "_valid_cycles"}, validCnt, lat);
      checkOutput({name, "_ready_after"}, int'(readyAfter), 1);
   endtask

   // Count stray mdu_done_o pulses over a window
   task automatic expectNoDone(input string name, input int cycles);
      int doneCnt = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (bus.mdu_done_o) doneCnt++;
      end
      checkOutput(name, doneCnt, 0);
   endtask

   // Monitor: a new op is presented when op_valid_o rises or follows a single-cycle op
   always @(negedge clk) begin
      if (!reset) begin
         prevValid = 1'b0;
         prevReady = 1'b1;
      end else begin
         if (bus.op_valid_o && (!prevValid || prevReady)) begin
            if (sb.size() == 0) begin
               tests++;
               failures++;
               $display("[TB] FAIL unexpected_op: op_valid_o=1 with op %0d, expected no operation",
                        bus.alu_operation_o);
            end else begin
               monE = sb.pop_front();
               checkOutput("sb_op", int'(bus.alu_operation_o), int'(monE.op));
               checkOutput("sb_illegal", int'(bus.illegal_o), int'(monE.ill));
               checkOutput("sb_stall", int'(bus.stall_o), int'(monE.mdu));
               checkOutput("sb_start", int'(bus.mdu_start_o), int'(monE.mdu));
               checkOutput("sb_ready", int'(bus.ready_o), int'(!monE.mdu));
            end
         end
         prevValid = bus.op_valid_o;
         prevReady = bus.ready_o;
      end
   end

   // Hard time limit so the run always ends
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed stimulus sequence
   initial begin
      tests        = 0;
      failures     = 0;
      prevValid    = 1'b0;
      prevReady    = 1'b1;
      reset        = 1'b0;
      bus.valid_i  = 1'b0;
      bus.flush_i  = 1'b0;
      bus.funct7_i = '0;
      bus.funct3_i = '0;
      bus.alu_op_i = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;

      @(negedge clk);
      checkOutput("rst_ready", int'(bus.ready_o), 1);
      checkOutput("rst_op_valid", int'(bus.op_valid_o), 0);
      checkOutput("rst_stall", int'(bus.stall_o), 0);
      checkOutput("rst_start", int'(bus.mdu_start_o), 0);
      checkOutput("rst_done", int'(bus.mdu_done_o), 0);
      checkOutput("rst_op", int'(bus.alu_operation_o), 0);
      checkOutput("rst_illegal", int'(bus.illegal_o), 0);

      // RV32I decode, issued back to back
      applyStimulus(F7_ALT,  3'b000, A_R,      5'd1,  1'b0, 1'b0);
      applyStimulus(F7_ALT,  3'b101, A_I,      5'd7,  1'b0, 1'b0);
      applyStimulus(F7_BASE, 3'b110, A_BRANCH, 5'd4,  1'b0, 1'b0);
      applyStimulus(F7_BASE, 3'b111, A_R,      5'd9,  1'b0, 1'b0);
      applyStimulus(F7_BASE, 3'b101, A_R,      5'd6,  1'b0, 1'b0);
      applyStimulus(F7_ALT,  3'b000, A_I,      5'd0,  1'b0, 1'b0);
      applyStimulus(F7_BASE, 3'b101, A_BRANCH, 5'd3,  1'b0, 1'b0);
      applyStimulus(7'h55,   3'b011, A_JAL,    5'd0,  1'b0, 1'b0);
      // Illegal encodings
      applyStimulus(F7_ALT,  3'b111, A_R,      5'd0,  1'b1, 1'b0);
      applyStimulus(F7_BASE, 3'b010, A_BRANCH, 5'd0,  1'b1, 1'b0);
      applyStimulus(F7_ALT,  3'b001, A_I,      5'd0,  1'b1, 1'b0);
      applyStimulus(7'b1000000, 3'b000, A_R,   5'd0,  1'b1, 1'b0);
      applyStimulus(F7_BASE, 3'b000, A_LUI,    5'd10, 1'b0, 1'b0);

      // Idle: op_valid_o drops, last decode is held
      repeat (2) @(negedge clk);
      checkOutput("idle_op_valid", int'(bus.op_valid_o), 0);
      checkOutput("idle_hold_op", int'(bus.alu_operation_o), 10);
      checkOutput("idle_hold_illegal", int'(bus.illegal_o), 0);

      // Flush together with valid in IDLE: no accept
      @(posedge clk);
      #1;
      bus.funct7_i = F7_BASE;
      bus.funct3_i = 3'b100;
      bus.alu_op_i = A_R;
      bus.valid_i  = 1'b1;
      bus.flush_i  = 1'b1;
      @(posedge clk);
      #1;
      bus.valid_i = 1'b0;
      bus.flush_i = 1'b0;
      @(negedge clk);
      checkOutput("idle_flush_op_valid", int'(bus.op_valid_o), 0);
      checkOutput("idle_flush_stall", int'(bus.stall_o), 0);
      checkOutput("idle_flush_hold_op", int'(bus.alu_operation_o), 10);

`ifdef ALU_OP_SEQ_RV32M_EN
      // DIV: 33 BUSY cycles
      applyStimulus(F7_MD, 3'b100, A_R, 5'd15, 1'b0, 1'b1);
      measureBusy("div", 33);
      // MULHU: 2 BUSY cycles
      applyStimulus(F7_MD, 3'b011, A_R, 5'd14, 1'b0, 1'b1);
      measureBusy("mulhu", 2);

      // Flush in BUSY cycle 5 of a REM
      applyStimulus(F7_MD, 3'b110, A_R, 5'd17, 1'b0, 1'b1);
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      bus.flush_i = 1'b1;
      @(negedge clk);
      checkOutput("busy_flush_stall_before", int'(bus.stall_o), 1);
      checkOutput("busy_flush_done_before", int'(bus.mdu_done_o), 0);
      @(posedge clk);
      #1;
      bus.flush_i = 1'b0;
      @(negedge clk);
      checkOutput("busy_flush_stall", int'(bus.stall_o), 0);
      checkOutput("busy_flush_ready", int'(bus.ready_o), 1);
      checkOutput("busy_flush_op_valid", int'(bus.op_valid_o), 0);
      checkOutput("busy_flush_done", int'(bus.mdu_done_o), 0);
      expectNoDone("busy_flush_no_done", 40);

      // Reset held for 2 cycles mid-DIV at cnt == 20
      applyStimulus(F7_MD, 3'b100, A_R, 5'd15, 1'b0, 1'b1);
      repeat (12) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
      @(negedge clk);
      checkOutput("mid_rst_done_during", int'(bus.mdu_done_o), 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      checkOutput("mid_rst_stall", int'(bus.stall_o), 0);
      checkOutput("mid_rst_ready", int'(bus.ready_o), 1);
      checkOutput("mid_rst_op_valid", int'(bus.op_valid_o), 0);
      checkOutput("mid_rst_done", int'(bus.mdu_done_o), 0);
      checkOutput("mid_rst_op", int'(bus.alu_operation_o), 0);
      expectNoDone("mid_rst_no_done", 40);

      // Sequencing still works after reset
      applyStimulus(F7_MD, 3'b000, A_R, 5'd11, 1'b0, 1'b1);
      measureBusy("mul_after_rst", 2);
`else
      // RV32M disabled: MUL/DIV encodings are illegal single-cycle ops
      applyStimulus(F7_MD, 3'b000, A_R, 5'd0, 1'b1, 1'b0);
      applyStimulus(F7_MD, 3'b100, A_R, 5'd0, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("nomdu_stall", int'(bus.stall_o), 0);
      checkOutput("nomdu_ready", int'(bus.ready_o), 1);
      expectNoDone("nomdu_no_done", 10);
`endif

      repeat (3) @(negedge clk);
      checkOutput("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
